// File: rtl/unidadcontrol_multiciclo.sv
// -----------------------------------------------------------------------------
// unidadcontrol_multiciclo
//
// Multicycle control unit for the RISC-V core. A Moore FSM sequences
// fetch, decode, execute, memory and writeback over a single shared
// instruction/data memory that answers with mem_ready_i. A wait-state
// watchdog moves the FSM to FAULT when memory does not answer in time.
//
// Optional feature macro: BRANCH_EXT_EN
//   defined   : bne/blt/bge are decoded in BRANCH, and jalr is supported
//               through a JALR state followed by a link writeback.
//   undefined : only beq can be taken, alu_lt_i has no effect, and
//               jalr is treated as an illegal opcode.
//
// Parameters
//   ALU_CTRL_W     width of alu_control_o (>=3), 3-bit code zero-extended
//   IMM_SRC_W      width of imm_src_o (>=3), 3-bit code zero-extended
//   TIMEOUT_CYCLES consecutive unready cycles tolerated before FAULT (>=1)
//
// Ports
//   clk_i, rst_i         clock, asynchronous active-high reset
//   op_i, funct3_i,
//   funct7b5_i           instruction fields from the instruction register
//   zero_i, alu_lt_i     ALU flags used by conditional branches
//   mem_ready_i          memory access completes this cycle
//   pc_write_o           PC write enable
//   adr_src_o            memory address: 0 PC, 1 ALUOut
//   ir_write_o           IR / oldPC write enable
//   mem_write_o          memory write enable
//   reg_write_o          register file write enable
//   result_src_o         00 ALUOut, 01 read data, 10 ALU result
//   alu_src_a_o          00 PC, 01 oldPC, 10 rs1, 11 zero
//   alu_src_b_o          00 rs2, 01 immediate, 10 constant 4
//   imm_src_o            000 I, 001 S, 010 B, 011 J, 100 U
//   alu_control_o        000 add, 001 sub, 010 and, 011 or, 101 slt
//   fault_o              FSM is in FAULT
//   state_o              current state encoding (debug)
// -----------------------------------------------------------------------------
module unidadcontrol_multiciclo #(
  parameter int ALU_CTRL_W     = 3,
  parameter int IMM_SRC_W      = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [6:0]            op_i,
  input  logic [2:0]            funct3_i,
  input  logic                  funct7b5_i,
  input  logic                  zero_i,
  input  logic                  alu_lt_i,
  input  logic                  mem_ready_i,
  output logic                  pc_write_o,
  output logic                  adr_src_o,
  output logic                  ir_write_o,
  output logic                  mem_write_o,
  output logic                  reg_write_o,
  output logic [1:0]            result_src_o,
  output logic [1:0]            alu_src_a_o,
  output logic [1:0]            alu_src_b_o,
  output logic [IMM_SRC_W-1:0]  imm_src_o,
  output logic [ALU_CTRL_W-1:0] alu_control_o,
  output logic                  fault_o,
  output logic [3:0]            state_o
);

`ifdef BRANCH_EXT_EN
  localparam logic BRANCH_EXT = 1'b1;
`else
  localparam logic BRANCH_EXT = 1'b0;
`endif

  // Opcodes handled by the decoder.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // ALU operation codes.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // ALU decoder selector.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Datapath mux encodings.
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // The counter only has to hold TIMEOUT_CYCLES-1: the unready cycle that
  // would reach the limit moves the FSM to FAULT and clears the counter.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_JALR     = 4'd12,
    S_JALRWB   = 4'd13,
    S_FAULT    = 4'd15
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic [CNT_W-1:0] wait_cnt_r;
  logic             wait_state_s;
  logic             timeout_s;
  logic             branch_taken_s;
  logic [1:0]       aluop_s;
  logic [2:0]       alu_code_s;
  logic [2:0]       imm_code_s;
  logic             pc_write_s;
  logic             ir_write_s;
  logic             mem_write_s;
  logic             reg_write_s;
  logic             adr_src_s;
  logic [1:0]       result_src_s;
  logic [1:0]       alu_src_a_s;
  logic [1:0]       alu_src_b_s;

  // ALU decoder: fixed add/sub, or funct3 decode for R/I-type arithmetic.
  // funct3=000 is sub only for R-type (op[5]=1) with bit 30 set; addi
  // with bit 30 set stays an add.
  function automatic logic [2:0] alu_decode(input logic [1:0] aluop,
                                            input logic [2:0] funct3,
                                            input logic       op5,
                                            input logic       funct7b5);
    logic [2:0] code;
    case (aluop)
      ALUOP_ADD: code = ALU_ADD;
      ALUOP_SUB: code = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  code = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  code = ALU_SLT;
          3'b110:  code = ALU_OR;
          3'b111:  code = ALU_AND;
          default: code = ALU_ADD;
        endcase
      end
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

  // Immediate format implied by the opcode.
  function automatic logic [2:0] imm_decode(input logic [6:0] op);
    logic [2:0] code;
    case (op)
      OP_STORE:  code = 3'b001;
      OP_BRANCH: code = 3'b010;
      OP_JAL:    code = 3'b011;
      OP_LUI:    code = 3'b100;
      default:   code = 3'b000;
    endcase
    return code;
  endfunction

  // Branch condition from funct3; only beq exists without the extension.
  always_comb begin
    branch_taken_s = 1'b0;
    case (funct3_i)
      3'b000:  branch_taken_s = zero_i;
      3'b001:  branch_taken_s = BRANCH_EXT & ~zero_i;
      3'b100:  branch_taken_s = BRANCH_EXT & alu_lt_i;
      3'b101:  branch_taken_s = BRANCH_EXT & ~alu_lt_i;
      default: branch_taken_s = 1'b0;
    endcase
  end

  // States that wait on the memory handshake and feed the watchdog.
  assign wait_state_s = (state_r == S_FETCH) || (state_r == S_MEMREAD) ||
                        (state_r == S_MEMWRITE);
  // Current unready cycle is the TIMEOUT_CYCLES-th consecutive one.
  assign timeout_s    = (wait_cnt_r == WAIT_LIMIT);

  // Next-state and Moore output decode, with the few ready/zero gated strobes.
  always_comb begin
    next_state_s = state_r;
    pc_write_s   = 1'b0;
    ir_write_s   = 1'b0;
    mem_write_s  = 1'b0;
    reg_write_s  = 1'b0;
    adr_src_s    = 1'b0;
    result_src_s = RES_ALUOUT;
    alu_src_a_s  = SRCA_PC;
    alu_src_b_s  = SRCB_RS2;
    aluop_s      = ALUOP_ADD;
    case (state_r)
      S_FETCH: begin
        alu_src_b_s  = SRCB_FOUR;
        result_src_s = RES_ALU;
        if (mem_ready_i) begin
          ir_write_s   = 1'b1;
          pc_write_s   = 1'b1;
          next_state_s = S_DECODE;
        end else if (timeout_s) begin
          next_state_s = S_FAULT;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        // Branch target oldPC+imm is computed here into ALUOut.
        alu_src_a_s = SRCA_OLDPC;
        alu_src_b_s = SRCB_IMM;
        case (op_i)
          OP_LOAD, OP_STORE: next_state_s = S_MEMADR;
          OP_RTYPE:          next_state_s = S_EXECUTER;
          OP_ITYPE:          next_state_s = S_EXECUTEI;
          OP_BRANCH:         next_state_s = S_BRANCH;
          OP_JAL:            next_state_s = S_JAL;
          OP_LUI:            next_state_s = S_LUI;
          OP_JALR:           next_state_s = BRANCH_EXT ? S_JALR : S_FAULT;
          default:           next_state_s = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_s = SRCA_RS1;
        alu_src_b_s = SRCB_IMM;
        if (op_i == OP_STORE) begin
          next_state_s = S_MEMWRITE;
        end else begin
          next_state_s = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        adr_src_s    = 1'b1;
        result_src_s = RES_ALUOUT;
        if (mem_ready_i) begin
          next_state_s = S_MEMWB;
        end else if (timeout_s) begin
          next_state_s = S_FAULT;
        end else begin
          next_state_s = S_MEMREAD;
        end
      end
      S_MEMWB: begin
        result_src_s = RES_DATA;
        reg_write_s  = 1'b1;
        next_state_s = S_FETCH;
      end
      S_MEMWRITE: begin
        // Write request is held until memory accepts it.
        adr_src_s   = 1'b1;
        mem_write_s = 1'b1;
        if (mem_ready_i) begin
          next_state_s = S_FETCH;
        end else if (timeout_s) begin
          next_state_s = S_FAULT;
        end else begin
          next_state_s = S_MEMWRITE;
        end
      end
      S_EXECUTER: begin
        alu_src_a_s  = SRCA_RS1;
        alu_src_b_s  = SRCB_RS2;
        aluop_s      = ALUOP_FUNCT;
        next_state_s = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a_s  = SRCA_RS1;
        alu_src_b_s  = SRCB_IMM;
        aluop_s      = ALUOP_FUNCT;
        next_state_s = S_ALUWB;
      end
      S_ALUWB: begin
        result_src_s = RES_ALUOUT;
        reg_write_s  = 1'b1;
        next_state_s = S_FETCH;
      end
      S_BRANCH: begin
        // ALU compares rs1-rs2 while PC takes the target held in ALUOut.
        alu_src_a_s  = SRCA_RS1;
        alu_src_b_s  = SRCB_RS2;
        aluop_s      = ALUOP_SUB;
        result_src_s = RES_ALUOUT;
        pc_write_s   = branch_taken_s;
        next_state_s = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target from ALUOut; ALU forms the link oldPC+4.
        alu_src_a_s  = SRCA_OLDPC;
        alu_src_b_s  = SRCB_FOUR;
        result_src_s = RES_ALUOUT;
        pc_write_s   = 1'b1;
        next_state_s = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a_s  = SRCA_ZERO;
        alu_src_b_s  = SRCB_IMM;
        next_state_s = S_ALUWB;
      end
      S_JALR: begin
        // Target rs1+imm goes straight from the ALU into the PC.
        alu_src_a_s  = SRCA_RS1;
        alu_src_b_s  = SRCB_IMM;
        result_src_s = RES_ALU;
        pc_write_s   = 1'b1;
        next_state_s = S_JALRWB;
      end
      S_JALRWB: begin
        // ALUOut still holds the jump target, so the link oldPC+4 is
        // written from the live ALU result instead.
        alu_src_a_s  = SRCA_OLDPC;
        alu_src_b_s  = SRCB_FOUR;
        result_src_s = RES_ALU;
        reg_write_s  = 1'b1;
        next_state_s = S_FETCH;
      end
      S_FAULT: begin
        next_state_s = S_FAULT;
      end
      default: begin
        next_state_s = S_FAULT;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Watchdog counter: consecutive unready cycles within the current state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt_r <= '0;
    end else if (next_state_s != state_r) begin
      wait_cnt_r <= '0;
    end else if (wait_state_s && !mem_ready_i) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  assign alu_code_s = alu_decode(aluop_s, funct3_i, op_i[5], funct7b5_i);
  assign imm_code_s = imm_decode(op_i);

  // Strobes are masked by the reset itself so nothing is written while it
  // is asserted, even before the state register has settled.
  assign pc_write_o    = pc_write_s  & ~rst_i;
  assign ir_write_o    = ir_write_s  & ~rst_i;
  assign mem_write_o   = mem_write_s & ~rst_i;
  assign reg_write_o   = reg_write_s & ~rst_i;
  assign adr_src_o     = adr_src_s;
  assign result_src_o  = result_src_s;
  assign alu_src_a_o   = alu_src_a_s;
  assign alu_src_b_o   = alu_src_b_s;
  assign imm_src_o     = IMM_SRC_W'(imm_code_s);
  assign alu_control_o = ALU_CTRL_W'(alu_code_s);
  assign fault_o       = (state_r == S_FAULT);
  assign state_o       = state_r;

endmodule

// File: tb/tb_unidadcontrol_multiciclo.sv
// Randomized self-checking bench for unidadcontrol_multiciclo. A reference
// model walks each instruction as a list of phases and predicts the
// control outputs of every cycle from the instruction class, the memory
// wait pattern and the ALU flags.
module tb_unidadcontrol_multiciclo;
  localparam int ACW = 5;
  localparam int IMW = 3;
  localparam int TMO = 16;

  localparam logic [4:0] A_ADD = 5'b00000;
  localparam logic [4:0] A_SUB = 5'b00001;
  localparam logic [4:0] A_AND = 5'b00010;
  localparam logic [4:0] A_OR  = 5'b00011;
  localparam logic [4:0] A_SLT = 5'b00101;

  typedef enum int {K_R, K_I, K_LW, K_SW, K_BR, K_JAL, K_LUI, K_JALR, K_ILL} kind_e;
  typedef enum int {P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
                    P_EXR, P_EXI, P_ALUWB, P_BRANCH, P_JAL, P_LUI, P_JALR, P_LINK,
                    P_FAULT} phase_e;

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b0;
  logic [6:0]     op_i = 7'b0000000;
  logic [2:0]     funct3_i = 3'b000;
  logic           funct7b5_i = 1'b0;
  logic           zero_i = 1'b0;
  logic           alu_lt_i = 1'b0;
  logic           mem_ready_i = 1'b1;
  logic           pc_write_o, adr_src_o, ir_write_o, mem_write_o, reg_write_o;
  logic [1:0]     result_src_o, alu_src_a_o, alu_src_b_o;
  logic [IMW-1:0] imm_src_o;
  logic [ACW-1:0] alu_control_o;
  logic           fault_o;
  logic [3:0]     state_o;

  int error_cnt = 0;
  int check_cnt = 0;

  logic [4:0] exp_alu;
  logic       exp_taken;
  int         exp_imm;
  logic       flt;

  logic [6:0] ill_ops [5] = '{7'b0000000, 7'b1111111, 7'b0010111, 7'b1110011, 7'b0001111};
  logic [2:0] alu_f3s [4] = '{3'b000, 3'b010, 3'b110, 3'b111};
  logic [2:0] br_f3s  [5] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b111};

  unidadcontrol_multiciclo #(
    .ALU_CTRL_W(ACW), .IMM_SRC_W(IMW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .op_i(op_i), .funct3_i(funct3_i),
    .funct7b5_i(funct7b5_i), .zero_i(zero_i), .alu_lt_i(alu_lt_i),
    .mem_ready_i(mem_ready_i), .pc_write_o(pc_write_o), .adr_src_o(adr_src_o),
    .ir_write_o(ir_write_o), .mem_write_o(mem_write_o), .reg_write_o(reg_write_o),
    .result_src_o(result_src_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
    .imm_src_o(imm_src_o), .alu_control_o(alu_control_o), .fault_o(fault_o),
    .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      error_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic rand_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int rand_lows(input int fault_odds);
    int r;
    r = int'($urandom_range(0, 63));
    if (r < 64 - 2 * fault_odds) return r % 4;
    else if (r < 64 - fault_odds) return TMO - 1;
    else return TMO;
  endfunction

  // Load the instruction fields and derive what it should do.
  task automatic setup(input kind_e kind, input logic [2:0] f3, input logic b5,
                       input logic z, input logic lt);
    funct3_i = f3; funct7b5_i = b5; zero_i = z; alu_lt_i = lt;
    exp_imm = -1;
    case (kind)
      K_R:    op_i = 7'b0110011;
      K_I:    begin op_i = 7'b0010011; exp_imm = 0; end
      K_LW:   begin op_i = 7'b0000011; exp_imm = 0; end
      K_SW:   begin op_i = 7'b0100011; exp_imm = 1; end
      K_BR:   begin op_i = 7'b1100011; exp_imm = 2; end
      K_JAL:  begin op_i = 7'b1101111; exp_imm = 3; end
      K_LUI:  begin op_i = 7'b0110111; exp_imm = 4; end
      K_JALR: op_i = 7'b1100111;
      default: op_i = ill_ops[$urandom_range(0, 4)];
    endcase
    case (f3)
      3'b000:  exp_alu = (kind == K_R && b5) ? A_SUB : A_ADD;
      3'b010:  exp_alu = A_SLT;
      3'b110:  exp_alu = A_OR;
      3'b111:  exp_alu = A_AND;
      default: exp_alu = A_ADD;
    endcase
    exp_taken = 1'b0;
    if (f3 == 3'b000) exp_taken = z;
`ifdef BRANCH_EXT_EN
    else if (f3 == 3'b001) exp_taken = !z;
    else if (f3 == 3'b100) exp_taken = lt;
    else if (f3 == 3'b101) exp_taken = !lt;
`endif
  endtask

  // One clock of a phase: drive ready, compare outputs, advance to next negedge.
  task automatic cyc(input phase_e ph, input logic rdy);
    logic [4:0] strb; // {pc, ir, mem, reg, fault}
    mem_ready_i = rdy;
    #1;
    strb = 5'b00000;
    case (ph)
      P_FETCH: begin
        strb = {rdy, rdy, 3'b000};
        check_eq("fetch_adr", 32'(adr_src_o), 32'd0);
        check_eq("fetch_a", 32'(alu_src_a_o), 32'd0);
        check_eq("fetch_b", 32'(alu_src_b_o), 32'd2);
        check_eq("fetch_res", 32'(result_src_o), 32'd2);
        check_eq("fetch_alu", 32'(alu_control_o), 32'(A_ADD));
      end
      P_DECODE: begin
        check_eq("dec_a", 32'(alu_src_a_o), 32'd1);
        check_eq("dec_b", 32'(alu_src_b_o), 32'd1);
        check_eq("dec_alu", 32'(alu_control_o), 32'(A_ADD));
        if (exp_imm >= 0) check_eq("dec_imm", 32'(imm_src_o), 32'(exp_imm));
      end
      P_MEMADR: begin
        check_eq("madr_a", 32'(alu_src_a_o), 32'd2);
        check_eq("madr_b", 32'(alu_src_b_o), 32'd1);
        check_eq("madr_alu", 32'(alu_control_o), 32'(A_ADD));
      end
      P_MEMREAD: begin
        check_eq("mrd_adr", 32'(adr_src_o), 32'd1);
        check_eq("mrd_res", 32'(result_src_o), 32'd0);
      end
      P_MEMWB: begin
        strb = 5'b00010;
        check_eq("mwb_res", 32'(result_src_o), 32'd1);
      end
      P_MEMWRITE: begin
        strb = 5'b00100;
        check_eq("mwr_adr", 32'(adr_src_o), 32'd1);
      end
      P_EXR, P_EXI: begin
        check_eq("ex_a", 32'(alu_src_a_o), 32'd2);
        check_eq("ex_b", 32'(alu_src_b_o), (ph == P_EXR) ? 32'd0 : 32'd1);
        check_eq("ex_alu", 32'(alu_control_o), 32'(exp_alu));
      end
      P_ALUWB: begin
        strb = 5'b00010;
        check_eq("awb_res", 32'(result_src_o), 32'd0);
      end
      P_BRANCH: begin
        strb = {exp_taken, 4'b0000};
        check_eq("br_a", 32'(alu_src_a_o), 32'd2);
        check_eq("br_b", 32'(alu_src_b_o), 32'd0);
        check_eq("br_alu", 32'(alu_control_o), 32'(A_SUB));
        check_eq("br_res", 32'(result_src_o), 32'd0);
      end
      P_JAL: begin
        strb = 5'b10000;
        check_eq("jal_a", 32'(alu_src_a_o), 32'd1);
        check_eq("jal_b", 32'(alu_src_b_o), 32'd2);
        check_eq("jal_res", 32'(result_src_o), 32'd0);
      end
      P_LUI: begin
        check_eq("lui_a", 32'(alu_src_a_o), 32'd3);
        check_eq("lui_b", 32'(alu_src_b_o), 32'd1);
        check_eq("lui_imm", 32'(imm_src_o), 32'd4);
        check_eq("lui_alu", 32'(alu_control_o), 32'(A_ADD));
      end
      P_JALR: begin
        strb = 5'b10000;
        check_eq("jalr_a", 32'(alu_src_a_o), 32'd2);
        check_eq("jalr_b", 32'(alu_src_b_o), 32'd1);
        check_eq("jalr_res", 32'(result_src_o), 32'd2);
      end
      P_LINK: begin
        strb = 5'b00010;
        check_eq("link_a", 32'(alu_src_a_o), 32'd1);
        check_eq("link_b", 32'(alu_src_b_o), 32'd2);
      end
      P_FAULT: strb = 5'b00001;
      default: strb = 5'b00000;
    endcase
    check_eq($sformatf("%s_strobes", ph.name()),
             32'({pc_write_o, ir_write_o, mem_write_o, reg_write_o, fault_o}), 32'(strb));
    @(negedge clk_i);
  endtask

  // A memory-wait phase: 'lows' unready cycles before ready, faulting at TMO.
  task automatic wait_phase(input phase_e ph, input int lows, output logic faulted);
    faulted = 1'b0;
    for (int k = 0; k <= TMO; k++) begin
      if (k == lows) begin
        cyc(ph, 1'b1);
        break;
      end
      cyc(ph, 1'b0);
      if (k + 1 == TMO) begin
        faulted = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_strobes",
             32'({pc_write_o, ir_write_o, mem_write_o, reg_write_o, fault_o}), 32'd0);
    check_eq("rst_adr", 32'(adr_src_o), 32'd0);
    check_eq("rst_b", 32'(alu_src_b_o), 32'd2);
    check_eq("rst_res", 32'(result_src_o), 32'd2);
    check_eq("rst_alu", 32'(alu_control_o), 32'(A_ADD));
  endtask

  // Assert reset between edges, hold it n more cycles with ready high.
  task automatic do_reset(input int n);
    #2;
    rst_i = 1'b1;
    mem_ready_i = 1'b1;
    #1;
    check_reset_outputs();
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      #1;
      check_reset_outputs();
    end
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic fault_and_reset();
    for (int i = 0; i < 3; i++) begin
      zero_i = rand_bit();
      cyc(P_FAULT, rand_bit());
    end
    do_reset(1);
  endtask

  // Walk one instruction through its expected phases.
  task automatic run(input kind_e kind, input int fetch_lows, input int mem_lows);
    logic f;
    wait_phase(P_FETCH, fetch_lows, f);
    if (!f) begin
      cyc(P_DECODE, rand_bit());
      case (kind)
        K_LW: begin
          cyc(P_MEMADR, rand_bit());
          wait_phase(P_MEMREAD, mem_lows, f);
          if (!f) cyc(P_MEMWB, rand_bit());
        end
        K_SW: begin
          cyc(P_MEMADR, rand_bit());
          wait_phase(P_MEMWRITE, mem_lows, f);
        end
        K_R:    begin cyc(P_EXR, rand_bit()); cyc(P_ALUWB, rand_bit()); end
        K_I:    begin cyc(P_EXI, rand_bit()); cyc(P_ALUWB, rand_bit()); end
        K_BR:   cyc(P_BRANCH, rand_bit());
        K_JAL:  begin cyc(P_JAL, rand_bit()); cyc(P_ALUWB, rand_bit()); end
        K_LUI:  begin cyc(P_LUI, rand_bit()); cyc(P_ALUWB, rand_bit()); end
`ifdef BRANCH_EXT_EN
        K_JALR: begin cyc(P_JALR, rand_bit()); cyc(P_LINK, rand_bit()); end
`endif
        default: f = 1'b1;
      endcase
    end
    if (f) fault_and_reset();
  endtask

  initial begin
    kind_e k;
    logic [2:0] f3;
    do_reset(3);

    // Directed: R-type sub, then the listed boundary cases.
    setup(K_R, 3'b000, 1'b1, 1'b0, 1'b0);  run(K_R, 0, 0);
    setup(K_I, 3'b000, 1'b1, 1'b0, 1'b0);  run(K_I, 0, 0);
    setup(K_LW, 3'b010, 1'b0, 1'b0, 1'b0); run(K_LW, 0, 3);
    setup(K_SW, 3'b010, 1'b0, 1'b0, 1'b0); run(K_SW, 0, TMO);
    setup(K_SW, 3'b010, 1'b0, 1'b0, 1'b0); run(K_SW, 0, TMO - 1);
    setup(K_BR, 3'b000, 1'b0, 1'b1, 1'b0); run(K_BR, 0, 0);
    setup(K_BR, 3'b000, 1'b0, 1'b0, 1'b0); run(K_BR, 0, 0);
    setup(K_BR, 3'b001, 1'b0, 1'b0, 1'b0); run(K_BR, 0, 0);
    setup(K_BR, 3'b100, 1'b0, 1'b0, 1'b1); run(K_BR, 0, 0);
    setup(K_ILL, 3'b000, 1'b0, 1'b0, 1'b0); op_i = 7'b0000000; run(K_ILL, 0, 0);
    setup(K_LUI, 3'b000, 1'b0, 1'b0, 1'b0); run(K_LUI, 0, 0);
    setup(K_JAL, 3'b000, 1'b0, 1'b0, 1'b0); run(K_JAL, 0, 0);
    setup(K_JALR, 3'b000, 1'b0, 1'b0, 1'b0); run(K_JALR, 0, 0);
    setup(K_R, 3'b110, 1'b0, 1'b0, 1'b0);  run(K_R, TMO, 0);
    setup(K_R, 3'b111, 1'b0, 1'b0, 1'b0);  run(K_R, TMO - 1, 0);

    // Directed: reset asserted while a store is waiting.
    setup(K_SW, 3'b010, 1'b0, 1'b0, 1'b0);
    wait_phase(P_FETCH, 0, flt);
    cyc(P_DECODE, 1'b1);
    cyc(P_MEMADR, 1'b0);
    cyc(P_MEMWRITE, 1'b0);
    cyc(P_MEMWRITE, 1'b0);
    mem_ready_i = 1'b0;
    #1;
    check_eq("mw_before_rst", 32'(mem_write_o), 32'd1);
    do_reset(1);
    setup(K_R, 3'b010, 1'b0, 1'b0, 1'b0);  run(K_R, 1, 0);

    // Randomized instruction stream.
    for (int n = 0; n < 200; n++) begin
      k = kind_e'($urandom_range(0, 8));
      if (k == K_BR) f3 = br_f3s[$urandom_range(0, 4)];
      else f3 = alu_f3s[$urandom_range(0, 3)];
      setup(k, f3, rand_bit(), rand_bit(), rand_bit());
      run(k, rand_lows(1), rand_lows(3));
    end

    $display("Result: errors=%0d of %0d checks", error_cnt, check_cnt);
    $finish;
  end
endmodule
